road_collision_detector: RTL and testbench
==========================================

# road_collision_detector

Consumer at the far end of the road-object drawing mux. Per pixel, it checks for overlap between the player car and the layer-classified drawing requests: car, truck, border, oil and fuel. It accumulates hits over a frame and reports at most one classified event of each kind at the next frame boundary. After a crash it enforces a frame-counted invulnerability window, and it keeps a saturating crash counter for the game-control logic.

## Interface
Parameters:
- COOLDOWN_FRAMES, 60, frames of crash immunity after a reported crash; legal range 1..255.

Ports:
- clk  in  1  system/pixel clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse at each frame start
- player_DR  in  1  player car drawing request for the current pixel
- car_DR  in  1  mux classification: enemy car pixel
- truck_DR  in  1  mux classification: truck pixel
- border_DR  in  1  road-edge or off-road pixel
- oil_DR  in  1  oil slick pixel
- fuel_DR  in  1  fuel symbol pixel
- crash_pulse  out  1  one-cycle pulse: crash reported this frame
- crash_type  out  2  valid with crash_pulse: 0 none, 1 car, 2 truck, 3 border
- oil_pulse  out  1  one-cycle pulse: oil slip reported
- fuel_pulse  out  1  one-cycle pulse: fuel pickup reported
- immune  out  1  level, high while in COOLDOWN
- crash_count  out  8  number of reported crashes, saturating

## Operation
- Hit sampling: on every clk, hit_X = player_DR & X_DR for X in {car, truck, border, oil, fuel}.
  - Each hit_X sets a sticky frame flag f_X.
- Frame boundary (startOfFrame = 1):
  - Current flags are evaluated.
  - Flags are then cleared.
  - Hits sampled in the same cycle as startOfFrame go into the new, cleared flags; they belong to the next frame.
- State machine, 2 states:
  - IDLE, at boundary:
    - If f_truck|f_car|f_border: pulse crash_pulse, load cooldown counter with COOLDOWN_FRAMES, go to COOLDOWN.
    - crash_type priority: truck(2) > car(1) > border(3).
    - crash_count increments by 1 per reported crash and saturates at 255.
    - If f_oil and no crash in that frame: pulse oil_pulse. A crash suppresses the oil report.
  - COOLDOWN, at boundary:
    - Crash and oil flags are discarded.
    - Counter decrements by 1.
    - If the counter was 1 (reaches 0), return to IDLE. Flags of that frame are still discarded.
- fuel_pulse fires at any boundary where f_fuel = 1, in either state, including the crash frame.
- All five flags are independent; multiple hits in one frame produce one report per kind, not one per pixel.
- immune = (state == COOLDOWN).
- crash_type holds its last value between pulses.

## Timing
- Reset (resetN low, async):
  - state IDLE; all flags 0; cooldown counter 0; crash_count 0.
  - crash_pulse, oil_pulse, fuel_pulse, immune = 0; crash_type = 0.
- Reset mid-frame or mid-cooldown discards all pending flags and immunity immediately.
- All outputs are registered.
- Pulses are asserted exactly in the cycle after the clk edge that samples startOfFrame = 1, and last exactly 1 cycle.
- immune rises in that same cycle as crash_pulse. It falls in the cycle after the boundary edge at which the counter reaches 0.
- With COOLDOWN_FRAMES = N, a crash reported at boundary B causes:
  - boundaries B+1..B+N to ignore crashes;
  - boundary B+N+1 to be the first able to report a crash.
- Back-to-back startOfFrame pulses (1-cycle frames) are legal; each is a full boundary.
- The block assumes the inputs are synchronous to clk and already pipeline-aligned with each other by the mux.

## Test plan
- Reset, then a frame with player_DR=1 and car_DR=1 for 3 cycles -> at the next boundary, a single crash_pulse with crash_type=1, crash_count=1, immune=1.
- One frame with both truck_DR and car_DR overlaps -> crash_type=2, one crash_pulse, crash_count increments by exactly 1.
- COOLDOWN_FRAMES=2; crash at boundary B, car overlap in every frame afterwards:
  - no crash_pulse at B+1 or B+2;
  - immune drops after B+2;
  - crash_pulse at B+3;
  - crash_count=2.
- A frame with oil and fuel overlap only -> oil_pulse=1 and fuel_pulse=1 in the same cycle.
- A frame with oil, fuel and border overlap -> crash_type=3, fuel_pulse=1, oil_pulse=0.
- Overlap asserted only in the startOfFrame cycle -> no report at that boundary; report at the following boundary.
- 260 crashes with COOLDOWN_FRAMES=1 -> crash_count saturates at 255.
- Assert resetN low mid-cooldown -> immune=0 and crash_count=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/road_collision_detector.sv
// ---------------------------------------------------------------------------
// road_collision_detector
//
// Purpose:
//   Sits after the road-object drawing mux and checks, pixel by pixel,
//   whether the player car overlaps any classified object (enemy car,
//   truck, road border, oil slick, fuel symbol). Overlaps are accumulated
//   into sticky per-frame flags and reported once per kind at the next
//   frame boundary. A reported crash starts a frame-counted immunity
//   window, and a saturating crash counter is kept for game control.
//
// Ports:
//   clk           in   pixel/system clock
//   resetN        in   asynchronous active-low reset
//   startOfFrame  in   one-cycle pulse marking each frame start
//   player_DR     in   player car drawing request
//   car_DR        in   enemy car pixel
//   truck_DR      in   truck pixel
//   border_DR     in   road edge / off-road pixel
//   oil_DR        in   oil slick pixel
//   fuel_DR       in   fuel symbol pixel
//   crash_pulse   out  one-cycle crash report
//   crash_type    out  0 none, 1 car, 2 truck, 3 border (held between pulses)
//   oil_pulse     out  one-cycle oil slip report
//   fuel_pulse    out  one-cycle fuel pickup report
//   immune        out  high while the immunity window is active
//   crash_count   out  saturating count of reported crashes
// ---------------------------------------------------------------------------
module road_collision_detector #(
  parameter int unsigned COOLDOWN_FRAMES = 60
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       player_DR,
  input  logic       car_DR,
  input  logic       truck_DR,
  input  logic       border_DR,
  input  logic       oil_DR,
  input  logic       fuel_DR,
  output logic       crash_pulse,
  output logic [1:0] crash_type,
  output logic       oil_pulse,
  output logic       fuel_pulse,
  output logic       immune,
  output logic [7:0] crash_count
);

  typedef enum logic {
    IDLE,
    COOLDOWN
  } state_t;

  localparam logic [7:0] COOLDOWN_LOAD = 8'(COOLDOWN_FRAMES);

  localparam logic [1:0] TYPE_CAR    = 2'd1;
  localparam logic [1:0] TYPE_TRUCK  = 2'd2;
  localparam logic [1:0] TYPE_BORDER = 2'd3;

  state_t     state;
  logic [7:0] cool_cnt;

  logic f_car, f_truck, f_border, f_oil, f_fuel;
  logic hit_car, hit_truck, hit_border, hit_oil, hit_fuel;
  logic frame_crash;

  assign hit_car    = player_DR & car_DR;
  assign hit_truck  = player_DR & truck_DR;
  assign hit_border = player_DR & border_DR;
  assign hit_oil    = player_DR & oil_DR;
  assign hit_fuel   = player_DR & fuel_DR;

  assign frame_crash = f_truck | f_car | f_border;

  // state is itself a flop, so immune is a registered output
  assign immune = (state == COOLDOWN);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      cool_cnt    <= 8'd0;
      f_car       <= 1'b0;
      f_truck     <= 1'b0;
      f_border    <= 1'b0;
      f_oil       <= 1'b0;
      f_fuel      <= 1'b0;
      crash_pulse <= 1'b0;
      crash_type  <= 2'd0;
      oil_pulse   <= 1'b0;
      fuel_pulse  <= 1'b0;
      crash_count <= 8'd0;
    end else begin
      crash_pulse <= 1'b0;
      oil_pulse   <= 1'b0;
      fuel_pulse  <= 1'b0;

      if (startOfFrame) begin
        // Hits seen on the boundary cycle belong to the new frame, so the
        // flags restart from this cycle's hits instead of from zero.
        f_car    <= hit_car;
        f_truck  <= hit_truck;
        f_border <= hit_border;
        f_oil    <= hit_oil;
        f_fuel   <= hit_fuel;

        fuel_pulse <= f_fuel;

        case (state)
          IDLE: begin
            if (frame_crash) begin
              crash_pulse <= 1'b1;
              if (f_truck)
                crash_type <= TYPE_TRUCK;
              else if (f_car)
                crash_type <= TYPE_CAR;
              else
                crash_type <= TYPE_BORDER;
              if (crash_count != 8'hFF)
                crash_count <= crash_count + 8'd1;
              cool_cnt <= COOLDOWN_LOAD;
              state    <= COOLDOWN;
            end else if (f_oil) begin
              oil_pulse <= 1'b1;
            end
          end
          COOLDOWN: begin
            // crash and oil flags of this frame are simply dropped
            cool_cnt <= cool_cnt - 8'd1;
            if (cool_cnt == 8'd1)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else begin
        f_car    <= f_car    | hit_car;
        f_truck  <= f_truck  | hit_truck;
        f_border <= f_border | hit_border;
        f_oil    <= f_oil    | hit_oil;
        f_fuel   <= f_fuel   | hit_fuel;
      end
    end
  end

endmodule

// File: tb/tb_road_collision_detector.sv
// ---------------------------------------------------------------------------
// tb_road_collision_detector
//
// Purpose:
//   Self-checking bench for road_collision_detector. Every driven cycle is
//   run through a frame-level reference model whose predicted outputs are
//   queued and then popped and compared against the DUT half a cycle later.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_road_collision_detector;

  localparam int N = 2;

  // drawing request bundle: {player, car, truck, border, oil, fuel}
  localparam logic [5:0] P      = 6'b100000;
  localparam logic [5:0] CAR    = 6'b010000;
  localparam logic [5:0] TRUCK  = 6'b001000;
  localparam logic [5:0] BORDER = 6'b000100;
  localparam logic [5:0] OIL    = 6'b000010;
  localparam logic [5:0] FUEL   = 6'b000001;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic       player_DR, car_DR, truck_DR, border_DR, oil_DR, fuel_DR;
  logic       crash_pulse;
  logic [1:0] crash_type;
  logic       oil_pulse;
  logic       fuel_pulse;
  logic       immune;
  logic [7:0] crash_count;

  road_collision_detector #(.COOLDOWN_FRAMES(N)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .player_DR    (player_DR),
    .car_DR       (car_DR),
    .truck_DR     (truck_DR),
    .border_DR    (border_DR),
    .oil_DR       (oil_DR),
    .fuel_DR      (fuel_DR),
    .crash_pulse  (crash_pulse),
    .crash_type   (crash_type),
    .oil_pulse    (oil_pulse),
    .fuel_pulse   (fuel_pulse),
    .immune       (immune),
    .crash_count  (crash_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       crash;
    logic [1:0] ctype;
    logic       oil;
    logic       fuel;
    logic       imm;
    logic [7:0] count;
  } expect_t;

  expect_t sb[$];

  int total = 0;
  int bad   = 0;

  // reference model state
  logic       m_car, m_truck, m_border, m_oil, m_fuel;
  int         m_cool;
  int         m_count;
  logic [1:0] m_type;

  task automatic modelReset();
    m_car = 0; m_truck = 0; m_border = 0; m_oil = 0; m_fuel = 0;
    m_cool = 0; m_count = 0; m_type = 2'd0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      if (bad <= 25)
        $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // advance the model by one sampled clock edge and queue the prediction
  task automatic modelClock(input logic sof, input logic [5:0] dr);
    expect_t    e;
    logic [4:0] h;
    h = dr[5] ? dr[4:0] : 5'b0;
    e = '0;
    if (sof) begin
      e.fuel = m_fuel;
      if (m_cool == 0) begin
        if (m_truck || m_car || m_border) begin
          e.crash = 1'b1;
          m_type  = m_truck ? 2'd2 : (m_car ? 2'd1 : 2'd3);
          if (m_count < 255) m_count++;
          m_cool  = N;
        end else begin
          e.oil = m_oil;
        end
      end else begin
        m_cool--;
      end
      {m_car, m_truck, m_border, m_oil, m_fuel} = h;
    end else begin
      {m_car, m_truck, m_border, m_oil, m_fuel} =
        {m_car, m_truck, m_border, m_oil, m_fuel} | h;
    end
    e.imm   = (m_cool != 0);
    e.ctype = m_type;
    e.count = m_count[7:0];
    sb.push_back(e);
  endtask

  // drive one cycle (called at a negedge), then compare at the next negedge
  task automatic applyStimulus(input logic sof, input logic [5:0] dr);
    expect_t e;
    startOfFrame = sof;
    {player_DR, car_DR, truck_DR, border_DR, oil_DR, fuel_DR} = dr;
    @(posedge clk);
    modelClock(sof, dr);
    @(negedge clk);
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      checkOutput("crash_pulse", {7'd0, crash_pulse}, {7'd0, e.crash});
      checkOutput("crash_type",  {6'd0, crash_type},  {6'd0, e.ctype});
      checkOutput("oil_pulse",   {7'd0, oil_pulse},   {7'd0, e.oil});
      checkOutput("fuel_pulse",  {7'd0, fuel_pulse},  {7'd0, e.fuel});
      checkOutput("immune",      {7'd0, immune},      {7'd0, e.imm});
      checkOutput("crash_count", crash_count,         e.count);
    end
  endtask

  // frame of len cycles: boundary cycle quiet, then hits for hit_cycles cycles
  task automatic runFrame(input int len, input logic [5:0] dr, input int hit_cycles);
    applyStimulus(1'b1, 6'd0);
    for (int i = 1; i < len; i++)
      applyStimulus(1'b0, (i <= hit_cycles) ? dr : 6'd0);
  endtask

  task automatic quietFrames(input int n);
    for (int i = 0; i < n; i++)
      runFrame(2, 6'd0, 0);
  endtask

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    {player_DR, car_DR, truck_DR, border_DR, oil_DR, fuel_DR} = 6'd0;
    modelReset();

    #2;
    checkOutput("rst_crash_pulse", {7'd0, crash_pulse}, 8'd0);
    checkOutput("rst_crash_type",  {6'd0, crash_type},  8'd0);
    checkOutput("rst_oil_pulse",   {7'd0, oil_pulse},   8'd0);
    checkOutput("rst_fuel_pulse",  {7'd0, fuel_pulse},  8'd0);
    checkOutput("rst_immune",      {7'd0, immune},      8'd0);
    checkOutput("rst_crash_count", crash_count,         8'd0);
    @(negedge clk);
    resetN = 1'b1;

    // car overlap for 3 cycles -> single car crash at the next boundary
    runFrame(5, P | CAR, 3);
    runFrame(3, 6'd0, 0);
    checkOutput("first_crash_count", crash_count, 8'd1);
    checkOutput("first_crash_imm",   {7'd0, immune}, 8'd1);
    checkOutput("first_crash_type",  {6'd0, crash_type}, 8'd1);

    // car overlap every frame during cooldown: only B+3 reports
    runFrame(3, P | CAR, 2);
    runFrame(3, P | CAR, 2);
    runFrame(3, P | CAR, 2);
    checkOutput("cooldown_count", crash_count, 8'd2);
    quietFrames(4);

    // truck and car together -> truck wins
    runFrame(4, P | CAR | TRUCK, 2);
    runFrame(2, 6'd0, 0);
    checkOutput("truck_type",  {6'd0, crash_type}, 8'd2);
    checkOutput("truck_count", crash_count, 8'd3);
    quietFrames(4);

    // oil and fuel only -> both pulses
    runFrame(4, P | OIL | FUEL, 2);
    runFrame(2, 6'd0, 0);

    // oil, fuel and border -> border crash, oil suppressed, fuel reported
    runFrame(4, P | OIL | FUEL | BORDER, 2);
    runFrame(2, 6'd0, 0);
    checkOutput("border_type", {6'd0, crash_type}, 8'd3);
    quietFrames(4);

    // overlap only on the boundary cycle belongs to the next frame
    applyStimulus(1'b1, P | CAR);
    applyStimulus(1'b0, 6'd0);
    applyStimulus(1'b0, 6'd0);
    runFrame(2, 6'd0, 0);
    quietFrames(4);

    // back-to-back one-cycle frames
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, (i % 2 == 0) ? (P | FUEL | CAR) : (P | OIL));
    quietFrames(4);

    // random traffic
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom_range(0, 2) == 0), 6'($urandom_range(0, 63)));
    quietFrames(4);

    // many crashes -> counter saturates
    for (int i = 0; i < 800; i++)
      runFrame(2, P | CAR | ((i % 7 == 0) ? FUEL : 6'd0), 1);
    checkOutput("saturated_count", crash_count, 8'd255);

    // enter cooldown, then reset asynchronously between edges
    quietFrames(4);
    runFrame(3, P | TRUCK, 1);
    runFrame(2, 6'd0, 0);
    checkOutput("pre_reset_immune", {7'd0, immune}, 8'd1);
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("async_immune", {7'd0, immune}, 8'd0);
    checkOutput("async_count",  crash_count, 8'd0);
    checkOutput("async_type",   {6'd0, crash_type}, 8'd0);
    modelReset();
    @(negedge clk);
    resetN = 1'b1;

    // pending flags were discarded; a fresh crash counts from zero
    runFrame(2, 6'd0, 0);
    runFrame(3, P | BORDER, 1);
    runFrame(2, 6'd0, 0);
    checkOutput("post_reset_count", crash_count, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
